// File: rtl/morphle_wb_loader.sv
// morphle_wb_loader
// Wishbone slave that loads and exercises one Morphle Logic yblock.
// Configuration words written to CBITS are queued in a small FIFO and
// shifted into the block's cbitin/confclk chain by a paced sequencer
// (IDLE -> SETUP -> HIGH -> HOLD, CLKDIV cycles per phase).
// Block reset and uin are register-driven; uout and cbitout are readable.
//
// Optional feature macro: MORPHLE_UOUT_SYNC_EN
//   defined   : uout/cbitout pass through a 2-flop synchronizer before readback
//   undefined : uout/cbitout are captured directly on the acking edge
//
// Wishbone handshake: an access is valid when cyc & stb. ack is registered as
// valid & !ack, so every access acks one cycle after it is presented, acks are
// never back-to-back, and writes/read data take effect on the acking edge.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   wbs_*                    Wishbone slave (adr[4:2] decoded)
//   blk_reset                yblock reset (CTRL.BRST, 1 after reset)
//   confclk, cbitin          yblock configuration chain
//   uin                      yblock stimulus (UIN register)
//   uout, cbitout            yblock outputs (readable)
//
// Register map (adr[4:2]):
//   0 CTRL    bit0 BRST, bit1 write-1 clears CNT/OVF (reads 0)
//   1 STATUS  bit0 BUSY, bit1 FULL, bit2 EMPTY, bit3 OVF, bit4 DONE, [15:8] CNT
//   2 CBITS   push configuration word (reads 0)
//   3 UIN     4 UOUT    5 CBITOUT    6,7 read 0
module morphle_wb_loader #(
  parameter int BLOCKWIDTH  = 16,
  parameter int BLOCKHEIGHT = 16,
  parameter int CLKDIV      = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic                    blk_reset,
  output logic                    confclk,
  output logic [BLOCKWIDTH-1:0]   cbitin,
  output logic [2*BLOCKWIDTH-1:0] uin,
  input  logic [2*BLOCKWIDTH-1:0] uout,
  input  logic [BLOCKWIDTH-1:0]   cbitout
);

  localparam int UW = 2 * BLOCKWIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_HIGH  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  // Bus decode
  logic       valid, access, wr_en;
  logic [2:0] reg_sel;
  logic       ctrl_wr, cnt_clr, push_req;

  assign valid    = wbs_cyc_i & wbs_stb_i;
  assign access   = valid & ~wbs_ack_o;
  assign wr_en    = access & wbs_we_i & (wbs_sel_i != 4'b0000);
  assign reg_sel  = wbs_adr_i[4:2];
  assign ctrl_wr  = wr_en & (reg_sel == 3'd0);
  assign cnt_clr  = ctrl_wr & wbs_dat_i[1];
  assign push_req = wr_en & (reg_sel == 3'd2);

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i};

  // Configuration-word FIFO
  logic [BLOCKWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           fill;
  logic                  full, empty, push, pop, overflow;

  logic [1:0] state;
  logic [7:0] div;
  logic       phase_end;
  logic [7:0] cnt;
  logic       ovf;

  assign full  = (fill == (AW+1)'(FIFO_DEPTH));
  assign empty = (fill == '0);
  assign pop   = (state == S_IDLE) & ~empty & ~blk_reset;
  // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
  assign push     = push_req & (~full | pop);
  assign overflow = push_req & full & ~pop;

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= wbs_dat_i[BLOCKWIDTH-1:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Sequencer: each phase lasts CLKDIV cycles; div counts within a phase.
  assign phase_end = (div == 8'(CLKDIV - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      div     <= '0;
      confclk <= 1'b0;
      cbitin  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            cbitin <= mem[rd_ptr];
            state  <= S_SETUP;
            div    <= '0;
          end
        end
        S_SETUP: begin
          if (phase_end) begin
            state   <= S_HIGH;
            confclk <= 1'b1;
            div     <= '0;
          end else div <= div + 1'b1;
        end
        S_HIGH: begin
          if (phase_end) begin
            state   <= S_HOLD;
            confclk <= 1'b0;
            div     <= '0;
          end else div <= div + 1'b1;
        end
        default: begin
          if (phase_end) begin
            state <= S_IDLE;
            div   <= '0;
          end else div <= div + 1'b1;
        end
      endcase
    end
  end

  // Word counter and sticky overflow; a software clear beats a same-edge increment.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (cnt_clr) cnt <= '0;
      else if ((state == S_HOLD) && phase_end) cnt <= cnt + 1'b1;
      if (cnt_clr) ovf <= 1'b0;
      else if (overflow) ovf <= 1'b1;
    end
  end

  // Control and stimulus registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      blk_reset <= 1'b1;
      uin       <= '0;
    end else begin
      if (ctrl_wr) blk_reset <= wbs_dat_i[0];
      if (wr_en && (reg_sel == 3'd3)) uin <= wbs_dat_i[UW-1:0];
    end
  end

  // Readback path for block outputs
  logic [UW-1:0]         uout_s;
  logic [BLOCKWIDTH-1:0] cbitout_s;

`ifdef MORPHLE_UOUT_SYNC_EN
  logic [UW-1:0]         uout_m;
  logic [BLOCKWIDTH-1:0] cbitout_m;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      uout_m    <= '0;
      uout_s    <= '0;
      cbitout_m <= '0;
      cbitout_s <= '0;
    end else begin
      uout_m    <= uout;
      uout_s    <= uout_m;
      cbitout_m <= cbitout;
      cbitout_s <= cbitout_m;
    end
  end
`else
  assign uout_s    = uout;
  assign cbitout_s = cbitout;
`endif

  // Read mux and Wishbone response
  logic        busy, done;
  logic [31:0] status, rdata;

  assign busy   = (state != S_IDLE) | ~empty;
  assign done   = ({24'b0, cnt} >= 32'(BLOCKHEIGHT));
  assign status = {16'b0, cnt, 3'b0, done, ovf, empty, full, busy};

  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0:    rdata[0] = blk_reset;
      3'd1:    rdata = status;
      3'd3:    rdata[UW-1:0] = uin;
      3'd4:    rdata[UW-1:0] = uout_s;
      3'd5:    rdata[BLOCKWIDTH-1:0] = cbitout_s;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= valid & ~wbs_ack_o;
      if (access) wbs_dat_o <= rdata;
    end
  end

endmodule
